// File: rtl/interrupt_ctrl.sv
// Interrupt controller: synchronises two external request lines, detects rising
// edges, latches pending requests and sequences a fixed-priority interrupt entry
// (one return-PC push plus vector select) followed by in-service tracking until RETI.
module interrupt_ctrl #(
  parameter int            AW   = 10,
  parameter logic [AW-1:0] VEC1 = AW'(512),
  parameter logic [AW-1:0] VEC2 = AW'(768)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irq1,
  input  logic          irq2,
  input  logic          int_en,
  input  logic [1:0]    mask,
  input  logic          reti,
  input  logic [AW-1:0] pc_ret,
  output logic          take_int,
  output logic [AW-1:0] vector,
  output logic          push_req,
  output logic [AW-1:0] push_data,
  output logic          in_service,
  output logic [1:0]    active_src,
  output logic [1:0]    pending,
  output logic          spurious_reti
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Bit 0 is IRQ1, bit 1 is IRQ2 throughout.
  logic [1:0] irq_in;
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] dly_q, dly_d;
  logic [1:0] pending_q, pending_d;
  logic [1:0] active_q, active_d;
  logic       spur_q, spur_d;
  state_t     state_q, state_d;

  logic [1:0] irq_edge;
  logic [1:0] eligible;
  logic [1:0] clr;
  logic       in_enter;

  assign irq_in   = {irq2, irq1};
  assign irq_edge = s2_q & ~dly_q;
  assign eligible = pending_q & ~mask & {2{int_en}};

  // Next-state logic: synchroniser shift, pending set/clear, arbitration and FSM.
  always_comb begin
    s1_d     = irq_in;
    s2_d     = s1_q;
    dly_d    = s2_q;
    state_d  = state_q;
    active_d = active_q;
    clr      = 2'b00;
    // RETI outside SERVICE is an error the CPU should never produce; remember it.
    spur_d   = spur_q | (reti & (state_q != SERVICE));

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = ENTER;
          // Fixed priority: IRQ1 beats IRQ2.
          active_d = eligible[0] ? 2'b01 : 2'b10;
        end
      end
      ENTER: begin
        state_d = SERVICE;
        clr     = active_q;
      end
      SERVICE: begin
        // No nesting: new edges only accumulate in pending until RETI.
        if (reti) begin
          state_d  = IDLE;
          active_d = 2'b00;
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = 2'b00;
      end
    endcase

    // A fresh edge coinciding with the clear keeps the request alive.
    pending_d = (pending_q & ~clr) | irq_edge;
  end

  // All state flops, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 2'b00;
      s2_q      <= 2'b00;
      dly_q     <= 2'b00;
      pending_q <= 2'b00;
      active_q  <= 2'b00;
      spur_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      dly_q     <= dly_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      spur_q    <= spur_d;
      state_q   <= state_d;
    end
  end

  // Outputs decoded from registered state; the push/vector pulse lasts exactly the ENTER cycle.
  always_comb begin
    in_enter      = (state_q == ENTER);
    take_int      = in_enter;
    push_req      = in_enter;
    vector        = in_enter ? (active_q[0] ? VEC1 : VEC2) : '0;
    push_data     = in_enter ? pc_ret : '0;
    in_service    = (state_q != IDLE);
    active_src    = active_q;
    pending       = pending_q;
    spurious_reti = spur_q;
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Testbench for interrupt_ctrl: directed stimulus; every expected interrupt entry
// is queued when stimulus is issued and a monitor checks each take_int pulse.
module tb_interrupt_ctrl;

  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          irq1;
  logic          irq2;
  logic          int_en;
  logic [1:0]    mask;
  logic          reti;
  logic [AW-1:0] pc_ret;
  logic          take_int;
  logic [AW-1:0] vector;
  logic          push_req;
  logic [AW-1:0] push_data;
  logic          in_service;
  logic [1:0]    active_src;
  logic [1:0]    pending;
  logic          spurious_reti;

  typedef struct {
    logic [AW-1:0] vec;
    logic [AW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  interrupt_ctrl #(.AW(AW), .VEC1(10'd512), .VEC2(10'd768)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq1          (irq1),
    .irq2          (irq2),
    .int_en        (int_en),
    .mask          (mask),
    .reti          (reti),
    .pc_ret        (pc_ret),
    .take_int      (take_int),
    .vector        (vector),
    .push_req      (push_req),
    .push_data     (push_data),
    .in_service    (in_service),
    .active_src    (active_src),
    .pending       (pending),
    .spurious_reti (spurious_reti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Move to the drive point of the next cycle (just after the rising edge).
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Move to the middle of the current cycle for sampling.
  task automatic look();
    @(negedge clk);
  endtask

  // One-cycle RETI pulse; returns in the cycle after the edge that sampled it.
  task automatic do_reti();
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  task automatic expect_entry(input logic [AW-1:0] v, input logic [AW-1:0] d);
    exp_t e;
    e.vec  = v;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every take_int cycle must match the oldest queued entry.
  always @(negedge clk) begin
    if (take_int === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry: got vector %0d push_data %0d, expected no entry at %0t",
                 vector, push_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_vector", 32'(vector), 32'(e.vec));
        chk("mon_push_data", 32'(push_data), 32'(e.data));
        chk("mon_push_req", 32'(push_req), 32'd1);
        $display("entry: vector=%0d push_data=%0d active_src=%b t=%0t",
                 vector, push_data, active_src, $time);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    irq1   = 1'b0;
    irq2   = 1'b0;
    int_en = 1'b1;
    mask   = 2'b00;
    reti   = 1'b0;
    pc_ret = 10'd37;

    // Reset state
    step(); step();
    look();
    chk("rst_take_int", 32'(take_int), 0);
    chk("rst_vector", 32'(vector), 0);
    chk("rst_push_req", 32'(push_req), 0);
    chk("rst_push_data", 32'(push_data), 0);
    chk("rst_in_service", 32'(in_service), 0);
    chk("rst_active_src", 32'(active_src), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_spurious", 32'(spurious_reti), 0);
    step();
    reset = 1'b0;
    step(); step();

    // Basic IRQ1 entry with latency check
    expect_entry(10'd512, 10'd37);
    irq1 = 1'b1;
    step(); step(); step();
    look();
    chk("t2_pending_set", 32'(pending), 32'b01);
    chk("t2_not_yet", 32'(in_service), 0);
    step(); look();
    chk("t2_take_int", 32'(take_int), 1);
    chk("t2_active", 32'(active_src), 32'b01);
    step(); look();
    chk("t2_single_pulse", 32'(take_int), 0);
    chk("t2_in_service", 32'(in_service), 1);
    chk("t2_pending_clr", 32'(pending), 0);
    step(); step(); look();
    chk("t2_hold_service", 32'(in_service), 1);
    irq1 = 1'b0;
    do_reti();
    look();
    chk("t2_back_idle", 32'(in_service), 0);
    chk("t2_active_clr", 32'(active_src), 0);
    step(); step(); step();

    // Simultaneous edges: IRQ1 first, one IDLE cycle, then IRQ2
    pc_ret = 10'd55;
    expect_entry(10'd512, 10'd55);
    expect_entry(10'd768, 10'd55);
    irq1 = 1'b1;
    irq2 = 1'b1;
    step(); step(); step();
    look();
    chk("t3_pending_both", 32'(pending), 32'b11);
    step(); look();
    chk("t3_first_active", 32'(active_src), 32'b01);
    step(); look();
    chk("t3_irq2_retained", 32'(pending), 32'b10);
    do_reti();
    look();
    chk("t3_idle_gap", 32'(in_service), 0);
    step(); look();
    chk("t3_second_take", 32'(take_int), 1);
    chk("t3_second_active", 32'(active_src), 32'b10);
    step(); look();
    chk("t3_pending_empty", 32'(pending), 0);
    irq1 = 1'b0;
    irq2 = 1'b0;
    do_reti();
    step(); step(); step();

    // New edge in the same cycle the pending bit clears: set wins
    pc_ret = 10'd90;
    expect_entry(10'd512, 10'd90);
    expect_entry(10'd512, 10'd90);
    irq1 = 1'b1;
    step();
    irq1 = 1'b0;
    step();
    irq1 = 1'b1;
    step(); look();
    chk("bnd_pending_first", 32'(pending), 32'b01);
    step(); look();
    chk("bnd_enter", 32'(take_int), 1);
    step(); look();
    chk("bnd_set_wins", 32'(pending), 32'b01);
    do_reti();
    look();
    chk("bnd_idle_gap", 32'(in_service), 0);
    step(); look();
    chk("bnd_reenter", 32'(take_int), 1);
    step(); look();
    chk("bnd_pending_done", 32'(pending), 0);
    irq1 = 1'b0;
    do_reti();
    step(); step(); step();

    // int_en low: pending held, serviced when enabled; int_en drop mid-service ignored
    pc_ret = 10'd200;
    int_en = 1'b0;
    irq2   = 1'b1;
    step(); step();
    irq2 = 1'b0;
    step(); look();
    chk("t4_pending", 32'(pending), 32'b10);
    for (int i = 0; i < 20; i++) begin
      step(); look();
      chk("t4_held", 32'({in_service, pending}), 32'b010);
    end
    expect_entry(10'd768, 10'd200);
    step();
    int_en = 1'b1;
    step(); look();
    chk("t4_enter_on_enable", 32'(take_int), 1);
    step();
    int_en = 1'b0;
    step(); look();
    chk("t4_service_kept", 32'({in_service, active_src}), 32'b110);
    do_reti();
    int_en = 1'b1;
    step(); step();

    // Masked source: pending kept, entry once unmasked
    pc_ret = 10'd300;
    mask = 2'b01;
    step();
    irq1 = 1'b1;
    step(); step(); step();
    look();
    chk("t5_pending", 32'(pending), 32'b01);
    repeat (5) step();
    look();
    chk("t5_no_entry", 32'({in_service, pending}), 32'b001);
    expect_entry(10'd512, 10'd300);
    step();
    mask = 2'b00;
    step(); look();
    chk("t5_enter_unmasked", 32'(take_int), 1);
    step(); look();
    chk("t5_pending_clr", 32'(pending), 0);
    irq1 = 1'b0;
    do_reti();
    step(); step(); step();

    // Spurious RETI in IDLE; a long level gives a single entry
    look();
    chk("t6_spur_before", 32'(spurious_reti), 0);
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    look();
    chk("t6_spur_set", 32'(spurious_reti), 1);
    chk("t6_still_idle", 32'(in_service), 0);
    pc_ret = 10'd400;
    expect_entry(10'd512, 10'd400);
    step();
    irq1 = 1'b1;
    step(); step(); step();
    step(); look();
    chk("t6_enter", 32'(take_int), 1);
    repeat (5) step();
    do_reti();
    repeat (40) step();
    look();
    chk("t6_single_entry", 32'({in_service, pending}), 0);
    chk("t6_spur_sticky", 32'(spurious_reti), 1);
    irq1 = 1'b0;
    step(); step(); step();

    // Reset mid-service with IRQ2 pending
    pc_ret = 10'd64;
    expect_entry(10'd512, 10'd64);
    irq1 = 1'b1;
    irq2 = 1'b1;
    step(); step(); step();
    step(); look();
    chk("t1_enter", 32'(take_int), 1);
    step(); look();
    chk("t1_pending_irq2", 32'(pending), 32'b10);
    step();
    reset = 1'b1;
    #1;
    chk("t1_async_outputs", 32'({take_int, push_req, in_service, active_src, spurious_reti}), 0);
    chk("t1_async_pending", 32'(pending), 0);
    chk("t1_async_vec_data", 32'({vector, push_data}), 0);
    irq1 = 1'b0;
    irq2 = 1'b0;
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    look();
    chk("t1_no_entry_after", 32'({in_service, pending}), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
